// File: rtl/pcileech_sysctl_led.sv
// System control: free-running tick counter, stretched core reset,
// per-channel LED modes with a power-on blink overlay.
module pcileech_sysctl_led #(
   parameter int NUM_LED          = 2,
   parameter int RST_HOLD_CYCLES  = 64,
   parameter int STRETCH_BITS     = 22,
   parameter int BLINK_BIT        = 24,
   parameter int PWRON_BLINK_BIT  = 24,
   parameter int PWRON_WINDOW_BIT = 27
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic [63:0]            tickcount64,
   output logic                   rst_out,
   output logic                   rst_out_n,
   input  logic [2*NUM_LED-1:0]   led_mode,
   input  logic [NUM_LED-1:0]     led_level,
   input  logic [NUM_LED-1:0]     led_act,
   input  logic                   pwron_en,
   output logic [NUM_LED-1:0]     led_out
);

   localparam int HW = $clog2(RST_HOLD_CYCLES + 1);
   localparam logic [HW-1:0] HOLD = HW'(RST_HOLD_CYCLES);
   localparam logic [31:0] STR_MAX = 32'((64'd1 << STRETCH_BITS) - 64'd1);

   logic [63:0]        tick_q, tick_d;
   logic [HW-1:0]      hold_q, hold_d;
   logic               rst_out_q, rst_out_d;
   logic               pdone_q, pdone_d;
   logic [31:0]        cnt_q [NUM_LED];
   logic [31:0]        cnt_d [NUM_LED];
   logic [NUM_LED-1:0] led_q, led_d;
   logic [NUM_LED-1:0] raw;
   logic               pwron;

   always_comb begin
      tick_d    = tick_q + 64'd1;
      hold_d    = (hold_q < HOLD) ? hold_q + HW'(1) : hold_q;
      rst_out_d = (hold_q < HOLD);
      // Sticky so the overlay cannot return after the counter wraps.
      pdone_d   = pdone_q | (tick_q[63:PWRON_WINDOW_BIT] != '0);
      pwron     = pwron_en & tick_q[PWRON_BLINK_BIT] &
                  (tick_q[63:PWRON_WINDOW_BIT] == '0) & ~pdone_q;
      raw       = '0;
      led_d     = '0;
      for (int i = 0; i < NUM_LED; i++) begin
         if (led_act[i])
            cnt_d[i] = STR_MAX;
         else if (cnt_q[i] != 32'd0)
            cnt_d[i] = cnt_q[i] - 32'd1;
         else
            cnt_d[i] = cnt_q[i];
         unique case (led_mode[2*i +: 2])
            2'b00: raw[i] = 1'b0;
            2'b01: raw[i] = led_level[i];
            2'b10: raw[i] = (cnt_q[i] != 32'd0);
            2'b11: raw[i] = tick_q[BLINK_BIT];
         endcase
         led_d[i] = raw[i] ^ pwron;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tick_q    <= '0;
         hold_q    <= '0;
         rst_out_q <= 1'b1;
         pdone_q   <= 1'b0;
         led_q     <= '0;
         for (int i = 0; i < NUM_LED; i++) cnt_q[i] <= '0;
      end else begin
         tick_q    <= tick_d;
         hold_q    <= hold_d;
         rst_out_q <= rst_out_d;
         pdone_q   <= pdone_d;
         led_q     <= led_d;
         for (int i = 0; i < NUM_LED; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign tickcount64 = tick_q;
   assign rst_out     = rst_out_q;
   assign rst_out_n   = ~rst_out_q;
   assign led_out     = led_q;

endmodule

// File: tb/tb_pcileech_sysctl_led.sv
// Bench for pcileech_sysctl_led: randomized stimulus against an
// event-age reference model (cycles since reset / since last pulse).
module tb_pcileech_sysctl_led;

   localparam int H   = 8;
   localparam int SB  = 4;
   localparam int STR = (1 << SB) - 1;
   localparam int BIG = 100000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] tickcount64;
   logic        rst_out, rst_out_n;
   logic [3:0]  led_mode = '0;
   logic [1:0]  led_level = '0;
   logic [1:0]  led_act = '0;
   logic        pwron_en = 1'b0;
   logic [1:0]  led_out;

   int vectors = 0;
   int errs    = 0;

   longint unsigned m_nlow = 0;
   int              m_age [2] = '{BIG, BIG};

   always #5 clk = ~clk;

   pcileech_sysctl_led #(
      .NUM_LED(2), .RST_HOLD_CYCLES(H), .STRETCH_BITS(SB),
      .BLINK_BIT(2), .PWRON_BLINK_BIT(3), .PWRON_WINDOW_BIT(6)
   ) dut (
      .clk(clk), .rst(rst), .tickcount64(tickcount64),
      .rst_out(rst_out), .rst_out_n(rst_out_n),
      .led_mode(led_mode), .led_level(led_level), .led_act(led_act),
      .pwron_en(pwron_en), .led_out(led_out)
   );

   task automatic step(input logic r, input logic [3:0] m,
                       input logic [1:0] lv, input logic [1:0] a,
                       input logic pe, input string tag);
      logic [63:0] e_tick;
      logic        e_ro;
      logic [1:0]  e_led;
      logic        pw, rw;
      @(negedge clk);
      rst = r; led_mode = m; led_level = lv; led_act = a; pwron_en = pe;
      if (r) begin
         e_tick = 0; e_ro = 1'b1; e_led = 2'b00;
      end else begin
         e_tick = m_nlow + 1;
         e_ro   = (m_nlow < H);
         pw = pe && m_nlow[3] && (m_nlow < 64);
         for (int i = 0; i < 2; i++) begin
            if (m[2*i +: 2] == 2'b00) rw = 1'b0;
            else if (m[2*i +: 2] == 2'b01) rw = lv[i];
            else if (m[2*i +: 2] == 2'b10) rw = (m_age[i] < STR);
            else rw = m_nlow[2];
            e_led[i] = rw ^ pw;
         end
      end
      if (r) begin
         m_nlow = 0;
         m_age  = '{BIG, BIG};
      end else begin
         m_nlow++;
         for (int i = 0; i < 2; i++)
            if (a[i]) m_age[i] = 0;
            else if (m_age[i] < BIG) m_age[i]++;
      end
      @(posedge clk);
      #1;
      vectors++;
      if (tickcount64 !== e_tick) begin
         errs++;
         $display("FAIL %s tick: got %0d want %0d", tag, tickcount64, e_tick);
      end
      vectors++;
      if (rst_out !== e_ro) begin
         errs++;
         $display("FAIL %s rst_out: got %b want %b", tag, rst_out, e_ro);
      end
      vectors++;
      if (rst_out_n !== ~e_ro) begin
         errs++;
         $display("FAIL %s rst_out_n: got %b want %b", tag, rst_out_n, ~e_ro);
      end
      vectors++;
      if (led_out !== e_led) begin
         errs++;
         $display("FAIL %s led_out: got %b want %b", tag, led_out, e_led);
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 5; i++) step(1, 4'b0000, 0, 0, 0, "reset_hi");
      for (int i = 0; i < 12; i++) step(0, 4'b0000, 0, 0, 0, "reset_lo");
      vectors++;
      if (tickcount64 !== 64'd12) begin
         errs++;
         $display("FAIL reset_count: got %0d want 12", tickcount64);
      end
   endtask

   task automatic test_rst_restart();
      step(1, 4'b0000, 0, 0, 0, "restart");
      for (int i = 0; i < 5; i++) step(0, 4'b0000, 0, 0, 0, "restart");
      step(1, 4'b0000, 0, 0, 0, "restart_pulse");
      for (int i = 0; i < 12; i++) step(0, 4'b0000, 0, 0, 0, "restart");
   endtask

   task automatic test_stretch();
      step(0, 4'b1010, 0, 2'b01, 0, "stretch_p1");
      for (int i = 0; i < 14; i++) step(0, 4'b1010, 0, 0, 0, "stretch");
      step(0, 4'b1010, 0, 2'b11, 0, "stretch_p2");
      for (int i = 0; i < 20; i++) step(0, 4'b1010, 0, 0, 0, "stretch");
   endtask

   task automatic test_blink_level();
      for (int i = 0; i < 20; i++) step(0, 4'b1111, 0, 0, 0, "blink");
      for (int i = 0; i < 8; i++) step(0, 4'b0101, 2'b11, 0, 0, "level");
      for (int i = 0; i < 4; i++) step(0, 4'b0101, 2'b01, 0, 0, "level");
   endtask

   task automatic test_pwron();
      step(1, 4'b0000, 0, 0, 1, "pwron_rst");
      for (int i = 0; i < 80; i++) step(0, 4'b0000, 0, 0, 1, "pwron");
      for (int i = 0; i < 10; i++) step(0, 4'b1101, 2'b10, 0, 1, "pwron_mix");
   endtask

   task automatic test_act_in_rst();
      step(1, 4'b1010, 0, 2'b11, 0, "act_rst");
      for (int i = 0; i < 20; i++) step(0, 4'b1010, 0, 0, 0, "act_rst");
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++)
         step(($urandom_range(0, 39) == 0), 4'($urandom),
              2'($urandom), 2'(($urandom_range(0, 5) == 0) ? $urandom : 0),
              1'($urandom), "random");
   endtask

   initial begin
      test_reset();
      test_rst_restart();
      test_stretch();
      test_blink_level();
      test_pwron();
      test_act_in_rst();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
